// File: rtl/sensor_response_tx_pkg.sv
// sensor_response_tx shared definitions: FSM encodings,
// response codes and the frame byte-order helper.
package sensor_response_tx_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

  // Response codes shared with the scheduler and sensor interfaces
  localparam logic [7:0] RSP_ACK  = 8'h08;
  localparam logic [7:0] RSP_DATA = 8'h09;
  localparam logic [7:0] RSP_NACK = 8'h15;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } frm_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Byte order on the wire: address (optional), response, data
  function automatic logic [7:0] frame_byte(
    input logic [1:0] idx,
    input logic       send_addr,
    input logic [7:0] addr,
    input logic [7:0] resp,
    input logic [7:0] data
  );
    logic [1:0] pos;
    pos = send_addr ? idx : idx + 2'd1;
    case (pos)
      2'd0:    frame_byte = addr;
      2'd1:    frame_byte = resp;
      default: frame_byte = data;
    endcase
  endfunction

endpackage

// File: rtl/sensor_response_tx_uart.sv
// uart_tx_byte: 8N1 serialiser for one byte, LSB first.
// A start in the last stop-bit cycle chains the next byte gaplessly.
module uart_tx_byte
  import sensor_response_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_done,
  output logic       busy
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == LAST);
  assign byte_done = (r_state == TX_STOP) && w_bit_end;
  assign busy      = (r_state != TX_IDLE);
  assign tx        = r_tx;

  // Bit sequencer: start, 8 data bits, stop; tx is registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        TX_IDLE: begin
          r_baud <= '0;
          if (start) begin
            r_state <= TX_START;
            r_shift <= byte_in;
            r_tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_state <= TX_DATA;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (start) begin
              r_state <= TX_START;
              r_shift <= byte_in;
              r_tx    <= 1'b0;
            end else begin
              r_state <= TX_IDLE;
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sensor_response_tx.sv
// sensor_response_tx: latches a scheduler response and
// sends it to the host as back-to-back UART bytes.
module sensor_response_tx
  import sensor_response_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned SEND_ADDR    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_decoder,
  input  logic [7:0] response_sensor,
  input  logic [7:0] data_sensor,
  input  logic [7:0] address_sensor,
  output logic       tx,
  output logic       done_decoder,
  output logic       busy
);

  localparam logic       W_SA     = (SEND_ADDR != 0);
  localparam logic [1:0] LAST_IDX = W_SA ? 2'd2 : 2'd1;

  frm_state_t r_state;
  logic [1:0] r_idx;
  logic [7:0] r_addr;
  logic [7:0] r_resp;
  logic [7:0] r_data;
  logic       r_done;
  logic       r_busy;

  logic       w_more;
  logic       w_start;
  logic       w_byte_done;
  logic       w_tx_busy;
  logic [1:0] w_sel;
  logic [7:0] w_byte;

  // Next byte is handed over during the last stop-bit cycle,
  // so the following start bit comes with no idle gap.
  assign w_more  = (r_idx != LAST_IDX);
  assign w_start = (r_state == LOAD) ||
                   ((r_state == SEND) && w_byte_done && w_more);
  assign w_sel   = (r_state == LOAD) ? r_idx : r_idx + 2'd1;
  assign w_byte  = frame_byte(w_sel, W_SA, r_addr, r_resp, r_data);

  assign done_decoder = r_done;
  assign busy         = r_busy;

  // Framer: accept, walk the byte list, then pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_resp  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (en_decoder && !w_tx_busy) begin
            r_addr  <= address_sensor;
            r_resp  <= response_sensor;
            r_data  <= data_sensor;
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_busy  <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (w_byte_done) begin
            if (w_more) begin
              r_idx <= r_idx + 2'd1;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .byte_in  (w_byte),
    .tx       (tx),
    .byte_done(w_byte_done),
    .busy     (w_tx_busy)
  );

endmodule

// File: tb/tb_sensor_response_tx.sv
// Directed bench for sensor_response_tx, CLKS_PER_BIT=4,
// one instance per SEND_ADDR setting.
module tb_sensor_response_tx;

  localparam int CPB = 4;
  localparam int FR  = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic [7:0] resp = 8'h00;
  logic [7:0] data = 8'h00;
  logic [7:0] addr = 8'h00;
  logic       tx0, tx1, done0, done1, busy0, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sensor_response_tx #(
    .CLKS_PER_BIT(CPB),
    .SEND_ADDR(0)
  ) u_dut0 (
    .clk            (clk),
    .reset          (reset),
    .en_decoder     (en0),
    .response_sensor(resp),
    .data_sensor    (data),
    .address_sensor (addr),
    .tx             (tx0),
    .done_decoder   (done0),
    .busy           (busy0)
  );

  sensor_response_tx #(
    .CLKS_PER_BIT(CPB),
    .SEND_ADDR(1)
  ) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .en_decoder     (en1),
    .response_sensor(resp),
    .data_sensor    (data),
    .address_sensor (addr),
    .tx             (tx1),
    .done_decoder   (done1),
    .busy           (busy1)
  );

  task automatic chk(input string tag, input int c,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b",
             tag, c, obs, exp);
    end
  endtask

  function automatic logic exp_tx(input int c, input int nb,
                                  input logic [7:0] e0,
                                  input logic [7:0] e1,
                                  input logic [7:0] e2);
    logic [7:0] b;
    int         p;
    int         bi;
    if (c < 1 || c > nb * FR) return 1'b1;
    bi = (c - 1) / FR;
    b  = (bi == 0) ? e0 : (bi == 1) ? e1 : e2;
    p  = ((c - 1) % FR) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en0 = v;
    else en1 = v;
  endtask

  task automatic start(input int sel, input logic [7:0] a,
                       input logic [7:0] r, input logic [7:0] d);
    @(posedge clk);
    #1;
    addr = a;
    resp = r;
    data = d;
    set_en(sel, 1'b1);
  endtask

  // mode 0 plain, 1 re-pulse at cycle 30, 2 en held,
  // 3 chain next en after done, 4 reset at cycle 25
  task automatic run_frame(input int sel, input int nb,
                           input logic [7:0] e0,
                           input logic [7:0] e1,
                           input logic [7:0] e2,
                           input int mode,
                           input logic [7:0] na,
                           input logic [7:0] nr,
                           input logic [7:0] nd);
    int last;
    logic t, dn, bz;
    @(posedge clk);
    #1;
    if (mode != 2) set_en(sel, 1'b0);
    last = (mode == 3) ? nb * FR + 2 : nb * FR + 3;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (mode == 1 && c == 30) begin
        addr = na; resp = nr; data = nd;
        set_en(sel, 1'b1);
      end
      if (mode == 1 && c == 31) set_en(sel, 1'b0);
      if (mode == 2 && c == 9) set_en(sel, 1'b0);
      if (mode == 3 && c == last) begin
        addr = na; resp = nr; data = nd;
        set_en(sel, 1'b1);
      end
      if (mode == 4 && c == 25) begin
        reset = 1'b1;
        #1;
        chk("rst_tx_async", c, sel ? tx1 : tx0, 1'b1);
        chk("rst_busy", c, sel ? busy1 : busy0, 1'b0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("rst_no_done", c + k, sel ? done1 : done0, 1'b0);
          chk("rst_tx_hold", c + k, sel ? tx1 : tx0, 1'b1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      t  = sel ? tx1 : tx0;
      dn = sel ? done1 : done0;
      bz = sel ? busy1 : busy0;
      chk("tx", c, t, exp_tx(c, nb, e0, e1, e2));
      chk("done", c, dn, c == nb * FR + 1);
      chk("busy", c, bz, c <= nb * FR + 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx0", 0, tx0, 1'b1);
    chk("reset_tx1", 0, tx1, 1'b1);
    chk("reset_busy0", 0, busy0, 1'b0);
    chk("reset_done0", 0, done0, 1'b0);
    chk("reset_busy1", 0, busy1, 1'b0);
    chk("reset_done1", 0, done1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_tx0", 0, tx0, 1'b1);
    chk("idle_busy0", 0, busy0, 1'b0);

    // Two-byte frame: 0x09 then 0x1A
    start(0, 8'h77, 8'h09, 8'h1A);
    run_frame(0, 2, 8'h09, 8'h1A, 8'h00, 0, 8'h0, 8'h0, 8'h0);

    // Three-byte frame with address first
    start(1, 8'h31, 8'h08, 8'h00);
    run_frame(1, 3, 8'h31, 8'h08, 8'h00, 0, 8'h0, 8'h0, 8'h0);

    // Mid-frame input change and re-pulse is ignored
    start(0, 8'h00, 8'h55, 8'hA3);
    run_frame(0, 2, 8'h55, 8'hA3, 8'h00, 1, 8'h00, 8'h3C, 8'h7E);
    start(0, 8'h00, 8'h3C, 8'h7E);
    run_frame(0, 2, 8'h3C, 8'h7E, 8'h00, 0, 8'h0, 8'h0, 8'h0);

    // en held for 10 cycles gives one frame
    start(0, 8'h00, 8'hC4, 8'h2B);
    run_frame(0, 2, 8'hC4, 8'h2B, 8'h00, 2, 8'h0, 8'h0, 8'h0);

    // Reset during a data bit aborts, then a clean frame
    start(0, 8'h00, 8'h09, 8'h1A);
    run_frame(0, 2, 8'h09, 8'h1A, 8'h00, 4, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    chk("post_rst_busy", 0, busy0, 1'b0);
    chk("post_rst_done", 0, done0, 1'b0);
    start(0, 8'h00, 8'h81, 8'hF0);
    run_frame(0, 2, 8'h81, 8'hF0, 8'h00, 0, 8'h0, 8'h0, 8'h0);

    // Back-to-back: en right after the done pulse
    start(0, 8'h00, 8'h12, 8'h34);
    run_frame(0, 2, 8'h12, 8'h34, 8'h00, 3, 8'h00, 8'hAB, 8'hCD);
    run_frame(0, 2, 8'hAB, 8'hCD, 8'h00, 0, 8'h0, 8'h0, 8'h0);

    // Back-to-back on the address-first instance
    start(1, 8'h5A, 8'hEE, 8'h01);
    run_frame(1, 3, 8'h5A, 8'hEE, 8'h01, 3, 8'hC3, 8'h15, 8'h80);
    run_frame(1, 3, 8'hC3, 8'h15, 8'h80, 0, 8'h0, 8'h0, 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
